// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 types, default bus widths and the write-controller state encoding.
package axi4_globals_pkg;

    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 64;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } awburst_e;

    typedef enum logic [2:0] {
        SIZE_1B, SIZE_2B, SIZE_4B, SIZE_8B,
        SIZE_16B, SIZE_32B, SIZE_64B, SIZE_128B
    } awsize_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } bresp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } wr_state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return len inside {8'd1, 8'd3, 8'd7, 8'd15};
    endfunction

endpackage

// File: rtl/axi4_slave_write_ctrl_if.sv
// AXI4 write channels (AW/W/B) plus the beat-level memory write port.
interface axi4_slave_write_ctrl_if #(
    parameter int ADDRESS_WIDTH = axi4_globals_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = axi4_globals_pkg::DATA_WIDTH
);
    logic [3:0]               awid;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [7:0]               awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
    logic                     awvalid;
    logic                     awready;

    logic [DATA_WIDTH-1:0]    wdata;
    logic [DATA_WIDTH/8-1:0]  wstrb;
    logic                     wlast;
    logic                     wvalid;
    logic                     wready;

    logic [3:0]               bid;
    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;

    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [DATA_WIDTH/8-1:0]  mem_be;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid,
        output mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bid, bresp, bvalid,
        input  mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Combinational AXI4 beat-address generator for FIXED, INCR and WRAP bursts.
module axi4_burst_addr_gen #(
    parameter int ADDRESS_WIDTH = axi4_globals_pkg::ADDRESS_WIDTH
) (
    input  logic [ADDRESS_WIDTH-1:0]    start_addr,
    input  logic [7:0]                  len,
    input  axi4_globals_pkg::awsize_e   size,
    input  axi4_globals_pkg::awburst_e  burst,
    input  logic [7:0]                  beat,
    output logic [ADDRESS_WIDTH-1:0]    beat_addr
);
    import axi4_globals_pkg::*;

    localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

    logic [ADDRESS_WIDTH-1:0] size_mask;
    logic [ADDRESS_WIDTH-1:0] incr_addr;
    logic [ADDRESS_WIDTH-1:0] wrap_mask;

    always_comb begin
        size_mask = (ONE << size) - ONE;
        incr_addr = (start_addr & ~size_mask) + (ADDRESS_WIDTH'(beat) << size);
        wrap_mask = ((ADDRESS_WIDTH'(len) + ONE) << size) - ONE;
        beat_addr = start_addr;
        // Beat 0 always goes to the unmodified start address.
        if (beat != 8'd0) begin
            case (burst)
                BURST_FIXED: beat_addr = start_addr;
                BURST_WRAP:  beat_addr = (start_addr & ~wrap_mask) | (incr_addr & wrap_mask);
                default:     beat_addr = incr_addr;
            endcase
        end
    end

endmodule

// File: rtl/axi4_slave_write_ctrl.sv
// Single-outstanding AXI4 write slave: accepts one burst, writes each beat to memory, returns B.
module axi4_slave_write_ctrl #(
    parameter int ADDRESS_WIDTH = axi4_globals_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = axi4_globals_pkg::DATA_WIDTH
) (
    input logic                    aclk,
    input logic                    areset,
    axi4_slave_write_ctrl_if.slave bus
);
    import axi4_globals_pkg::*;

    localparam int STRB_W = DATA_WIDTH / 8;

    wr_state_e                state_q, state_d;
    logic                     rst_done_q;
    logic [3:0]               id_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [7:0]               len_q;
    logic [7:0]               beat_q;
    awsize_e                  size_q;
    awburst_e                 burst_q;
    logic                     cfg_err_q;
    logic                     last_err_q;
    logic                     cfg_err_d;
    logic                     aw_hs, w_hs, b_hs, final_beat;
    logic [ADDRESS_WIDTH-1:0] beat_addr;
    logic [ADDRESS_WIDTH-1:0] size_mask;

    logic                     mem_vld_p1;
    logic [ADDRESS_WIDTH-1:0] mem_addr_p1;
    logic [DATA_WIDTH-1:0]    mem_wdata_p1;
    logic [STRB_W-1:0]        mem_be_p1;

    // awready waits one edge after reset release so it is never seen high during reset.
    assign bus.awready = (state_q == ST_IDLE) && rst_done_q;
    assign bus.wready  = (state_q == ST_DATA);
    assign bus.bvalid  = (state_q == ST_RESP);
    assign bus.bid     = id_q;
    assign bus.bresp   = (cfg_err_q || last_err_q) ? RESP_SLVERR : RESP_OKAY;

    assign aw_hs      = bus.awvalid && bus.awready;
    assign w_hs       = bus.wvalid && bus.wready;
    assign b_hs       = bus.bvalid && bus.bready;
    assign final_beat = (beat_q == len_q);
    assign size_mask  = (ADDRESS_WIDTH'(1) << bus.awsize) - ADDRESS_WIDTH'(1);

    always_comb begin
        cfg_err_d = 1'b0;
        if (bus.awburst == BURST_RSVD)
            cfg_err_d = 1'b1;
        if ((32'd1 << bus.awsize) > 32'(STRB_W))
            cfg_err_d = 1'b1;
        if (bus.awburst == BURST_WRAP &&
            (!wrap_len_ok(bus.awlen) || (bus.awaddr & size_mask) != '0))
            cfg_err_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (aw_hs)              state_d = ST_DATA;
            ST_DATA: if (w_hs && final_beat) state_d = ST_RESP;
            ST_RESP: if (b_hs)               state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    axi4_burst_addr_gen #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_addr_gen (
        .start_addr (addr_q),
        .len        (len_q),
        .size       (size_q),
        .burst      (burst_q),
        .beat       (beat_q),
        .beat_addr  (beat_addr)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            rst_done_q   <= 1'b0;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= SIZE_1B;
            burst_q      <= BURST_FIXED;
            beat_q       <= '0;
            cfg_err_q    <= 1'b0;
            last_err_q   <= 1'b0;
            mem_vld_p1   <= 1'b0;
            mem_addr_p1  <= '0;
            mem_wdata_p1 <= '0;
            mem_be_p1    <= '0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
            mem_vld_p1 <= 1'b0;
            if (aw_hs) begin
                id_q       <= bus.awid;
                addr_q     <= bus.awaddr;
                len_q      <= bus.awlen;
                size_q     <= awsize_e'(bus.awsize);
                burst_q    <= awburst_e'(bus.awburst);
                beat_q     <= '0;
                cfg_err_q  <= cfg_err_d;
                last_err_q <= 1'b0;
            end
            // Stage p1: registered memory write for the beat accepted this cycle.
            if (w_hs) begin
                if (!final_beat)
                    beat_q <= beat_q + 8'd1;
                if (bus.wlast != final_beat)
                    last_err_q <= 1'b1;
                mem_vld_p1   <= !cfg_err_q;
                mem_addr_p1  <= beat_addr;
                mem_wdata_p1 <= bus.wdata;
                mem_be_p1    <= bus.wstrb;
            end
        end
    end

    assign bus.mem_we    = mem_vld_p1;
    assign bus.mem_addr  = mem_addr_p1;
    assign bus.mem_wdata = mem_wdata_p1;
    assign bus.mem_be    = mem_be_p1;

endmodule

// File: doc/axi4_slave_write_ctrl.md
AXI4_SLAVE_WRITE_CTRL -- requirements
Module: axi4_slave_write_ctrl

Interface
REQ-001 Parameters SHALL be: ADDRESS_WIDTH, default 32, address bus width; DATA_WIDTH, default 64, data bus width in bits (power of 2, 8..1024).
REQ-002 Ports SHALL be: aclk in 1, the single clock; areset in 1, asynchronous active-high reset.
REQ-003 AW ports SHALL be: awid in 4; awaddr in ADDRESS_WIDTH; awlen in 8; awsize in 3; awburst in 2; awvalid in 1; awready out 1.
REQ-004 W ports SHALL be: wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wlast in 1; wvalid in 1; wready out 1.
REQ-005 B ports SHALL be: bid out 4; bresp out 2; bvalid out 1; bready in 1.
REQ-006 Memory ports SHALL be: mem_we out 1, write strobe; mem_addr out ADDRESS_WIDTH, beat address; mem_wdata out DATA_WIDTH; mem_be out DATA_WIDTH/8, byte enables.

Function
REQ-007 FSM SHALL have states IDLE, DATA and RESP; IDLE->DATA on AW handshake; DATA->RESP on the W handshake of beat awlen+1; RESP->IDLE on B handshake.
REQ-008 awready SHALL be 1 only in IDLE, wready 1 only in DATA, and bvalid 1 only in RESP.
REQ-009 On AW handshake, awid, awaddr, awlen, awsize and awburst SHALL be registered, and the beat counter SHALL be cleared.
REQ-010 Beat 0 address SHALL be awaddr unmodified.
REQ-011 FIXED (00) bursts SHALL use awaddr for every beat.
REQ-012 INCR (01) bursts SHALL use, for beat n>0, (awaddr aligned down to 2^awsize) + n*2^awsize, modulo 2^ADDRESS_WIDTH.
REQ-013 WRAP (10) bursts SHALL wrap the INCR address within a window of (awlen+1)*2^awsize bytes based at awaddr rounded down to that size.
REQ-014 Each W handshake of an accepted, error-free burst SHALL produce one mem_we pulse in the next cycle, with mem_addr = beat address, mem_wdata = wdata and mem_be = wstrb.
REQ-015 SLVERR (10) SHALL be flagged when any of these holds: awburst=11; 2^awsize > DATA_WIDTH/8; WRAP with awlen not in {1,3,7,15}; WRAP with awaddr unaligned to 2^awsize.
REQ-016 A flagged burst SHALL still accept exactly awlen+1 beats, SHALL issue no mem_we pulse, and SHALL respond SLVERR.
REQ-017 wlast mismatch (wlast=1 before the final beat, or wlast=0 on the final beat) SHALL set SLVERR and SHALL NOT end the burst early; memory writes up to that point stand.
REQ-018 bresp SHALL be OKAY (00) when no error was flagged; EXOKAY and DECERR SHALL never be generated.
REQ-019 bid SHALL equal the registered awid.
REQ-020 bvalid SHALL rise in the cycle after the final W handshake and SHALL hold, with bid and bresp stable, until bready.
REQ-021 awready SHALL reassert in the cycle after the B handshake; there is one outstanding write at a time and no AW/W overlap.
REQ-022 W beats presented while in IDLE SHALL be ignored and held off with wready=0.
REQ-023 awlen=0 SHALL be a single-beat burst.
REQ-024 The beat counter SHALL be 8 bits; 256-beat bursts SHALL complete without overflow.

Reset
REQ-025 While areset=1, the FSM SHALL be in IDLE and the error flag and beat counter SHALL be 0.
REQ-026 While areset=1, outputs SHALL be: awready=0, wready=0, bvalid=0, bid=0, bresp=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
REQ-027 awready SHALL assert in the first clock edge after areset deasserts.
REQ-028 Reset asserted mid-burst SHALL abandon the burst, with no pending mem_we and no B response.

Structure
REQ-029 awburst_e, awsize_e, bresp_e, ADDRESS_WIDTH and DATA_WIDTH SHALL come from axi4_globals_pkg; the FSM state enum SHALL be added to that package.
REQ-030 Beat-address computation SHALL live in the sub-module axi4_burst_addr_gen, a combinational block with inputs (start addr, len, size, burst, beat index) and output (beat addr).

Verification
REQ-031 INCR, awaddr=0x1004, awlen=3, awsize=2 -> mem_addr 0x1004, 0x1008, 0x100C, 0x1010; bresp=00; bid echoed.
REQ-032 WRAP, awaddr=0x38, awlen=3, awsize=3 -> mem_addr 0x38, 0x20, 0x28, 0x30; bresp=00.
REQ-033 awburst=11, awlen=1 -> 2 beats accepted, zero mem_we pulses, bresp=10.
REQ-034 awlen=2 with wlast=1 on beat 1 -> 3 beats accepted, 3 writes, bresp=10.
REQ-035 bready held 0 for 5 cycles -> bvalid, bid and bresp stable for 5 cycles, awready=0 throughout, awready=1 the cycle after the handshake.
REQ-036 areset pulsed after beat 2 of 4 -> all outputs 0, then a fresh AW is accepted and completes with OKAY.
